// File: rtl/riscv_pkg.sv
// Shared constants for the bimodal branch history table: counter encodings,
// sweep FSM states and the PC bit where the table index starts.
package riscv_pkg;

    localparam logic [1:0] CTR_SNT = 2'b00;
    localparam logic [1:0] CTR_WNT = 2'b01;
    localparam logic [1:0] CTR_WT  = 2'b10;
    localparam logic [1:0] CTR_ST  = 2'b11;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } bht_state_e;

    // Instructions are word aligned, so PC[1:0] carry no index information.
    localparam int PC_IDX_LSB = 2;

endpackage

// File: rtl/bht_sat_ctr.sv
// Two-bit saturating counter next-state logic: taken counts up towards
// strongly-taken, not-taken counts down towards strongly-not-taken.
module bht_sat_ctr
    import riscv_pkg::*;
(
    input  logic [1:0] ctr,
    input  logic       taken,
    output logic [1:0] next_ctr
);

    always_comb begin
        next_ctr = ctr;
        if (taken) begin
            if (ctr != CTR_ST) next_ctr = ctr + 2'd1;
        end else begin
            if (ctr != CTR_SNT) next_ctr = ctr - 2'd1;
        end
    end

endmodule

// File: rtl/branch_predictor_bht.sv
// Bimodal branch history table with a post-reset init sweep.
// Optional macro BHT_PERF_CNT_EN adds branch and mispredict counters.
module branch_predictor_bht
    import riscv_pkg::*;
#(
    parameter int         INDEX_BITS = 6,
    parameter logic [1:0] INIT_CTR   = 2'b01
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_valid,
    input  logic [31:0] fetch_pc,
    output logic        pred_valid,
    output logic        pred_taken,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic        upd_pred,
    output logic        mispredict,
    output logic        ready
`ifdef BHT_PERF_CNT_EN
    ,
    output logic [31:0] br_count,
    output logic [31:0] mis_count
`endif
);

    localparam int ENTRIES = 1 << INDEX_BITS;

    logic [1:0]            table_mem [ENTRIES];
    bht_state_e            state, state_next;
    logic [INDEX_BITS-1:0] init_idx, init_idx_next;
    logic [INDEX_BITS-1:0] fidx, uidx;
    logic [1:0]            upd_ctr, upd_ctr_next;
    logic                  wr_en;
    logic [INDEX_BITS-1:0] wr_idx;
    logic [1:0]            wr_data;
    logic                  run, upd_fire;
    logic                  unused_pc_bits;

    assign fidx     = fetch_pc[PC_IDX_LSB +: INDEX_BITS];
    assign uidx     = upd_pc[PC_IDX_LSB +: INDEX_BITS];
    assign run      = (state == ST_RUN);
    assign upd_fire = run && upd_valid;
    assign ready    = run;
    assign upd_ctr  = table_mem[uidx];

    // Upper PC bits intentionally alias into the same entry.
    assign unused_pc_bits = ^{fetch_pc[31:PC_IDX_LSB+INDEX_BITS], fetch_pc[PC_IDX_LSB-1:0],
                              upd_pc[31:PC_IDX_LSB+INDEX_BITS], upd_pc[PC_IDX_LSB-1:0]};

    bht_sat_ctr u_sat_ctr (
        .ctr      (upd_ctr),
        .taken    (upd_taken),
        .next_ctr (upd_ctr_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_INIT;
            init_idx <= '0;
        end else begin
            state    <= state_next;
            init_idx <= init_idx_next;
        end
    end

    // The single write port is owned by the sweep in INIT and by training in RUN.
    always_comb begin
        state_next    = state;
        init_idx_next = init_idx;
        wr_en         = 1'b0;
        wr_idx        = uidx;
        wr_data       = upd_ctr_next;
        case (state)
            ST_INIT: begin
                wr_en         = 1'b1;
                wr_idx        = init_idx;
                wr_data       = INIT_CTR;
                init_idx_next = init_idx + INDEX_BITS'(1);
                if (&init_idx) state_next = ST_RUN;
            end
            ST_RUN: begin
                wr_en = upd_valid;
            end
            default: begin
                state_next = ST_INIT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_en && !rst) table_mem[wr_idx] <= wr_data;
    end

    // Lookup reads the pre-update counter when it collides with a training write.
    always_ff @(posedge clk) begin
        if (rst) begin
            pred_valid <= 1'b0;
            pred_taken <= 1'b0;
            mispredict <= 1'b0;
        end else begin
            pred_valid <= run && fetch_valid;
            pred_taken <= run && fetch_valid && table_mem[fidx][1];
            mispredict <= upd_fire && (upd_taken ^ upd_pred);
        end
    end

`ifdef BHT_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            br_count  <= '0;
            mis_count <= '0;
        end else if (upd_fire) begin
            br_count <= br_count + 32'd1;
            if (upd_taken != upd_pred) mis_count <= mis_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_branch_predictor_bht.sv
// Self-checking bench for branch_predictor_bht: init sweep, a table of
// directed one-cycle vectors, and a mid-run reset sequence.
module tb_branch_predictor_bht;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_valid;
    logic [31:0] fetch_pc;
    logic        pred_valid;
    logic        pred_taken;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic        upd_pred;
    logic        mispredict;
    logic        ready;
`ifdef BHT_PERF_CNT_EN
    logic [31:0] br_count;
    logic [31:0] mis_count;
`endif

    int testsRun    = 0;
    int testsFailed = 0;
    int expBr       = 0;
    int expMis      = 0;

    always #5 clk = ~clk;

    branch_predictor_bht #(
        .INDEX_BITS (6),
        .INIT_CTR   (2'b01)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .fetch_valid (fetch_valid),
        .fetch_pc    (fetch_pc),
        .pred_valid  (pred_valid),
        .pred_taken  (pred_taken),
        .upd_valid   (upd_valid),
        .upd_pc      (upd_pc),
        .upd_taken   (upd_taken),
        .upd_pred    (upd_pred),
        .mispredict  (mispredict),
        .ready       (ready)
`ifdef BHT_PERF_CNT_EN
        ,
        .br_count    (br_count),
        .mis_count   (mis_count)
`endif
    );

    typedef struct {
        string       name;
        logic        fv;
        logic [31:0] fpc;
        logic        uv;
        logic [31:0] upc;
        logic        ut;
        logic        up;
        logic        epv;
        logic        ept;
        logic        emis;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input string n, input logic fv, input logic [31:0] fpc,
                                input logic uv, input logic [31:0] upc, input logic ut,
                                input logic up, input logic epv, input logic ept,
                                input logic emis);
        vec_t v;
        v.name = n; v.fv = fv; v.fpc = fpc; v.uv = uv; v.upc = upc;
        v.ut = ut; v.up = up; v.epv = epv; v.ept = ept; v.emis = emis;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Drive one vector between edges and sample just after the next rising edge.
    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        fetch_valid = v.fv;
        fetch_pc    = v.fpc;
        upd_valid   = v.uv;
        upd_pc      = v.upc;
        upd_taken   = v.ut;
        upd_pred    = v.up;
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs.push_back(mk("fetch100_wnt",     1, 32'h100, 0, 32'h0,   0, 0, 1, 0, 0));
        vecs.push_back(mk("upd100_T_mis",     0, 32'h0,   1, 32'h100, 1, 0, 0, 0, 1));
        vecs.push_back(mk("refetch100_wt",    1, 32'h100, 0, 32'h0,   0, 0, 1, 1, 0));
        vecs.push_back(mk("sat104_T1",        0, 32'h0,   1, 32'h104, 1, 1, 0, 0, 0));
        vecs.push_back(mk("sat104_T2",        0, 32'h0,   1, 32'h104, 1, 1, 0, 0, 0));
        vecs.push_back(mk("sat104_T3",        0, 32'h0,   1, 32'h104, 1, 1, 0, 0, 0));
        vecs.push_back(mk("sat104_T4",        0, 32'h0,   1, 32'h104, 1, 1, 0, 0, 0));
        vecs.push_back(mk("fetch104_st",      1, 32'h104, 0, 32'h0,   0, 0, 1, 1, 0));
        vecs.push_back(mk("sat104_NT1",       0, 32'h0,   1, 32'h104, 0, 1, 0, 0, 1));
        vecs.push_back(mk("fetch104_wt",      1, 32'h104, 0, 32'h0,   0, 0, 1, 1, 0));
        vecs.push_back(mk("sat104_NT2",       0, 32'h0,   1, 32'h104, 0, 1, 0, 0, 1));
        vecs.push_back(mk("fetch104_wnt",     1, 32'h104, 0, 32'h0,   0, 0, 1, 0, 0));
        vecs.push_back(mk("sat110_NT1",       0, 32'h0,   1, 32'h110, 0, 0, 0, 0, 0));
        vecs.push_back(mk("sat110_NT2",       0, 32'h0,   1, 32'h110, 0, 0, 0, 0, 0));
        vecs.push_back(mk("sat110_NT3",       0, 32'h0,   1, 32'h110, 0, 0, 0, 0, 0));
        vecs.push_back(mk("sat110_NT4",       0, 32'h0,   1, 32'h110, 0, 0, 0, 0, 0));
        vecs.push_back(mk("sat110_T",         0, 32'h0,   1, 32'h110, 1, 0, 0, 0, 1));
        vecs.push_back(mk("fetch110_wnt",     1, 32'h110, 0, 32'h0,   0, 0, 1, 0, 0));
        vecs.push_back(mk("fetch114_fresh",   1, 32'h114, 0, 32'h0,   0, 0, 1, 0, 0));
        vecs.push_back(mk("alias214_T1",      0, 32'h0,   1, 32'h214, 1, 0, 0, 0, 1));
        vecs.push_back(mk("alias214_T2",      0, 32'h0,   1, 32'h214, 1, 1, 0, 0, 0));
        vecs.push_back(mk("alias_fetch114",   1, 32'h114, 0, 32'h0,   0, 0, 1, 1, 0));
        vecs.push_back(mk("collide108",       1, 32'h108, 1, 32'h108, 1, 0, 1, 0, 1));
        vecs.push_back(mk("after_collide108", 1, 32'h108, 0, 32'h0,   0, 0, 1, 1, 0));
        vecs.push_back(mk("train10c_T1",      0, 32'h0,   1, 32'h10C, 1, 0, 0, 0, 1));
        vecs.push_back(mk("train10c_T2",      0, 32'h0,   1, 32'h10C, 1, 1, 0, 0, 0));
        vecs.push_back(mk("fetch10c_st",      1, 32'h10C, 0, 32'h0,   0, 0, 1, 1, 0));

        // Reset with fetch held high through the sweep.
        rst         = 1'b1;
        fetch_valid = 1'b1;
        fetch_pc    = 32'h100;
        upd_valid   = 1'b0;
        upd_pc      = 32'h0;
        upd_taken   = 1'b0;
        upd_pred    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_ready", {31'b0, ready}, 32'd0);
        checkOutput("reset_pred_valid", {31'b0, pred_valid}, 32'd0);
        checkOutput("reset_mispredict", {31'b0, mispredict}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 1; c <= 64; c++) begin
            @(posedge clk);
            #1;
            if (c < 64) checkOutput($sformatf("init_ready_c%0d", c), {31'b0, ready}, 32'd0);
            else        checkOutput("init_ready_c64", {31'b0, ready}, 32'd1);
            checkOutput($sformatf("init_pred_valid_c%0d", c), {31'b0, pred_valid}, 32'd0);
        end
        @(posedge clk);
        #1;
        checkOutput("first_pred_valid", {31'b0, pred_valid}, 32'd1);
        checkOutput("first_pred_taken", {31'b0, pred_taken}, 32'd0);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            if (vecs[i].uv) begin
                expBr++;
                if (vecs[i].ut != vecs[i].up) expMis++;
            end
            checkOutput({vecs[i].name, "_pred_valid"}, {31'b0, pred_valid}, {31'b0, vecs[i].epv});
            checkOutput({vecs[i].name, "_pred_taken"}, {31'b0, pred_taken}, {31'b0, vecs[i].ept});
            checkOutput({vecs[i].name, "_mispredict"}, {31'b0, mispredict}, {31'b0, vecs[i].emis});
        end
`ifdef BHT_PERF_CNT_EN
        checkOutput("br_count_run", br_count, 32'(expBr));
        checkOutput("mis_count_run", mis_count, 32'(expMis));
`endif

        // Mid-run reset: training on 0x10C must be wiped by the new sweep.
        @(negedge clk);
        rst         = 1'b1;
        fetch_valid = 1'b1;
        fetch_pc    = 32'h10C;
        upd_valid   = 1'b1;
        upd_pc      = 32'h10C;
        upd_taken   = 1'b1;
        upd_pred    = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("midrst_ready", {31'b0, ready}, 32'd0);
        checkOutput("midrst_pred_valid", {31'b0, pred_valid}, 32'd0);
        checkOutput("midrst_mispredict", {31'b0, mispredict}, 32'd0);
`ifdef BHT_PERF_CNT_EN
        checkOutput("midrst_br_count", br_count, 32'd0);
        checkOutput("midrst_mis_count", mis_count, 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
        for (int c = 1; c <= 64; c++) begin
            @(posedge clk);
            #1;
            checkOutput($sformatf("resweep_pred_valid_c%0d", c), {31'b0, pred_valid}, 32'd0);
            checkOutput($sformatf("resweep_mispredict_c%0d", c), {31'b0, mispredict}, 32'd0);
        end
        checkOutput("resweep_ready", {31'b0, ready}, 32'd1);
        @(negedge clk);
        upd_valid   = 1'b0;
        fetch_valid = 1'b1;
        fetch_pc    = 32'h10C;
        @(posedge clk);
        #1;
        checkOutput("post_reset_pred_valid", {31'b0, pred_valid}, 32'd1);
        checkOutput("post_reset_pred_taken", {31'b0, pred_taken}, 32'd0);
`ifdef BHT_PERF_CNT_EN
        checkOutput("post_reset_br_count", br_count, 32'd0);
        checkOutput("post_reset_mis_count", mis_count, 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/branch_predictor_bht.md
Name: branch_predictor_bht

Overview:
Bimodal branch history table: 2^INDEX_BITS two-bit saturating counters indexed by PC.
- Fetch side: looks up a taken/not-taken prediction for the fetch PC, with a registered output aligned to decode.
- Execute side: consumes the resolved outcome from the branch encoder (Encoded_Branch, qualified by Branch), trains the counter and flags mispredicts to the PC-select/flush logic.
- After reset, an internal sweep FSM initialises the table.

Parameters:
- INDEX_BITS, 6, table index width; the table has 2^INDEX_BITS entries.
- INIT_CTR, 2'b01, counter value written during the init sweep (weakly not-taken).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- fetch_valid  in  1  fetch PC valid this cycle.
- fetch_pc  in  32  fetch-stage PC.
- pred_valid  out  1  registered; prediction valid.
- pred_taken  out  1  registered; predicted direction.
- upd_valid  in  1  resolved conditional branch this cycle (Branch asserted in EX).
- upd_pc  in  32  PC of the resolved branch.
- upd_taken  in  1  actual outcome (Encoded_Branch).
- upd_pred  in  1  prediction originally issued for this branch, carried down the pipe.
- mispredict  out  1  registered one-cycle pulse; upd_taken differs from upd_pred.
- ready  out  1  high once the table is initialised (state RUN).

Behaviour:
- Index = pc[INDEX_BITS+1:2], used for both fetch_pc and upd_pc. Upper PC bits are ignored, so aliasing is permitted.
- Counter encoding: 00 strongly not-taken (SNT), 01 weakly not-taken (WNT), 10 weakly taken (WT), 11 strongly taken (ST). Predict taken = bit 1.
- Training:
  - Taken: increment, saturating at 11.
  - Not-taken: decrement, saturating at 00.
- Reset (rst=1 at an edge):
  - state=INIT, init_idx=0.
  - pred_valid=0, pred_taken=0, mispredict=0, ready=0.
  - Table contents are don't-care until swept.
- INIT state:
  - Each cycle writes INIT_CTR to table[init_idx], then init_idx+1.
  - At init_idx = 2^INDEX_BITS-1: write, then state becomes RUN.
  - ready rises exactly 2^INDEX_BITS cycles after rst deasserts.
  - fetch_valid and upd_valid are ignored; pred_valid and mispredict stay 0.
- RUN state, prediction (latency 1):
  - At the edge, pred_valid <= fetch_valid.
  - pred_taken <= table[fidx][1] if fetch_valid, else 0.
- RUN state, update:
  - At the edge with upd_valid=1: table[uidx] <= sat(table[uidx], upd_taken).
  - mispredict <= upd_taken ^ upd_pred.
  - With upd_valid=0: mispredict <= 0.
- Same-cycle lookup and update on the same index:
  - The prediction uses the pre-update counter (read-before-write).
  - The next lookup sees the updated value.
- Update during the cycle ready rises: applied, since the FSM is already in RUN at that edge.
- Reset mid-operation: takes effect at the next edge. Outputs clear, the sweep restarts at index 0 and all training is lost.
- Only one write port is used; INIT writes and RUN writes are mutually exclusive by state.

Optional Feature:
- Macro: BHT_PERF_CNT_EN.
- Defined:
  - Adds outputs br_count[31:0] and mis_count[31:0].
  - br_count increments on every accepted update.
  - mis_count increments when, in addition, upd_taken != upd_pred.
  - Both wrap at 2^32, reset to 0 on rst, and do not count during INIT.
- Undefined: neither port nor counter exists; behaviour is otherwise identical.

Decomposition:
- Shared package (riscv_pkg): localparams CTR_SNT/CTR_WNT/CTR_WT/CTR_ST, FSM state codes ST_INIT/ST_RUN, and the PC-index LSB constant (2).
- One natural sub-module: bht_sat_ctr, combinational next-counter from (ctr[1:0], taken). It is unit-testable over all 8 input combinations.

Test Plan:
- Init sweep:
  - Stimulus: rst high 2 cycles, then low with fetch_valid=1 held.
  - Required: ready=0 and pred_valid=0 for 64 cycles; ready=1 on cycle 64; pred_valid=1 on the following cycle.
- Train and mispredict:
  - Stimulus: fetch 0x100, giving pred_taken=0; then upd_valid, upd_pc=0x100, upd_taken=1, upd_pred=0.
  - Required: mispredict is a 1-cycle pulse; a refetch of 0x100 gives pred_taken=1 (counter 10).
- Saturation:
  - Stimulus: 4 taken updates at 0x104, then 1 not-taken.
  - Required: prediction stays 1 (11→10); a second not-taken flips it to 0 (01).
  - Also: 3 not-taken updates from 00 keep the counter at 00.
- Aliasing:
  - Stimulus: 0x100 and 0x200 share index 0; train 0x200 taken twice.
  - Required: fetching 0x100 returns pred_taken=1.
- Same-cycle collision:
  - Stimulus: fetch 0x108 while updating 0x108 taken, from WNT.
  - Required: pred_taken=0 that cycle, 1 on the next fetch.
- Reset mid-run:
  - Stimulus: train 0x10C to ST, assert rst for 1 cycle.
  - Required: ready=0 next cycle; after 64 cycles, fetch 0x10C gives pred_taken=0.
  - With BHT_PERF_CNT_EN defined: br_count and mis_count read 0.
